// File: rtl/hack_cpu.sv
// Hack CPU: single-cycle A/D/PC datapath, instruction decode and jump logic around the Hack ALU.
// hack_alu is the ALU the CPU instantiates; it is kept in this file so the design stays self-contained.

module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = zx ? 16'h0000 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? 16'h0000 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end
endmodule

module hack_cpu #(
  parameter int unsigned PC_W     = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instruction,
  input  logic [15:0]     inM,
  output logic [15:0]     outM,
  output logic            writeM,
  output logic [PC_W-1:0] addressM,
  output logic [PC_W-1:0] pc
);
  logic [15:0]     a_q, a_d, d_q, d_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     alu_y, alu_out;
  logic            alu_zr, alu_ng;
  logic            is_c, sel_m, dst_a, dst_d, dst_m, jump;
  logic            unused_bits;

  // Instruction field decode
  assign is_c        = instruction[15];
  assign sel_m       = instruction[12];
  assign dst_a       = instruction[5];
  assign dst_d       = instruction[4];
  assign dst_m       = instruction[3];
  assign unused_bits = ^instruction[14:13];

  assign alu_y = sel_m ? inM : a_q;

  hack_alu u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (instruction[11]),
    .nx  (instruction[10]),
    .zy  (instruction[9]),
    .ny  (instruction[8]),
    .f   (instruction[7]),
    .no  (instruction[6]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump = is_c & ((instruction[2] & alu_ng) |
                        (instruction[1] & alu_zr) |
                        (instruction[0] & ~alu_ng & ~alu_zr));

  // Next-state: destinations and jump both see the pre-update A
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + PC_W'(1);
    if (!is_c) begin
      a_d = instruction;
    end else begin
      if (dst_a) a_d = alu_out;
      if (dst_d) d_d = alu_out;
    end
    if (jump) pc_d = a_q[PC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= PC_W'(RESET_PC);
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  assign outM     = alu_out;
  assign writeM   = is_c & dst_m & ~reset;
  assign addressM = a_q[PC_W-1:0];
  assign pc       = pc_q;
endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu: per-cycle vector table plus a hand-written mid-run reset sequence.

module tb_hack_cpu;
  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int n_pass;
  int n_total;

  hack_cpu #(.PC_W(15), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: [3]=outM [2]=writeM [1]=addressM [0]=pc
  typedef struct {
    logic        rst;
    logic [15:0] ins;
    logic [15:0] inm;
    logic [3:0]  mask;
    logic [15:0] out;
    logic        wr;
    logic [14:0] addr;
    logic [14:0] pcv;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic rst, logic [15:0] ins, logic [15:0] inm, logic [3:0] mask,
                              logic [15:0] out, logic wr, logic [14:0] addr, logic [14:0] pcv);
    vec_t v;
    v.rst = rst; v.ins = ins; v.inm = inm; v.mask = mask;
    v.out = out; v.wr = wr; v.addr = addr; v.pcv = pcv;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [15:0] ins, input logic [15:0] inm);
    @(negedge clk);
    reset = rst;
    instruction = ins;
    inM = inm;
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    instruction = 16'hFFFF;
    inM = 16'h0000;

    //            rst  ins       inM      mask     outM     wr    addr   pc
    vecs[0]  = mk(1, 16'hFFFF, 16'h0000, 4'b0100, 16'h0000, 1'b0, 15'd0,     15'd0);
    vecs[1]  = mk(1, 16'hFFFF, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd0,     15'd0);
    vecs[2]  = mk(0, 16'h0015, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd0,     15'd0);   // @21
    vecs[3]  = mk(0, 16'hEC10, 16'h0000, 4'b1111, 16'd21,   1'b0, 15'd21,    15'd1);   // D=A
    vecs[4]  = mk(0, 16'hE308, 16'h0000, 4'b1111, 16'd21,   1'b1, 15'd21,    15'd2);   // M=D
    vecs[5]  = mk(0, 16'hF090, 16'd3,    4'b1111, 16'd24,   1'b0, 15'd21,    15'd3);   // D=D+M
    vecs[6]  = mk(0, 16'hE308, 16'd3,    4'b1111, 16'd24,   1'b1, 15'd21,    15'd4);   // M=D
    vecs[7]  = mk(0, 16'h0064, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd21,    15'd5);   // @100
    vecs[8]  = mk(0, 16'hE301, 16'h0000, 4'b1111, 16'd24,   1'b0, 15'd100,   15'd6);   // D;JGT taken
    vecs[9]  = mk(0, 16'hEA90, 16'h0000, 4'b1111, 16'd0,    1'b0, 15'd100,   15'd100); // D=0
    vecs[10] = mk(0, 16'hE301, 16'h0000, 4'b1111, 16'd0,    1'b0, 15'd100,   15'd101); // D;JGT not taken
    vecs[11] = mk(0, 16'hEE90, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'd100,   15'd102); // D=-1
    vecs[12] = mk(0, 16'hE304, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'd100,   15'd103); // D;JLT taken
    vecs[13] = mk(0, 16'hFCA8, 16'd5,    4'b1111, 16'd4,    1'b1, 15'd100,   15'd100); // AM=M-1
    vecs[14] = mk(0, 16'hEA87, 16'd5,    4'b1111, 16'd0,    1'b0, 15'd4,     15'd101); // 0;JMP
    vecs[15] = mk(0, 16'h7FFF, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd4,     15'd4);   // @32767
    vecs[16] = mk(0, 16'hEA87, 16'h0000, 4'b1111, 16'd0,    1'b0, 15'd32767, 15'd5);   // 0;JMP
    vecs[17] = mk(0, 16'h0007, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd32767, 15'd32767); // @7
    vecs[18] = mk(1, 16'hEC10, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd7,     15'd0);   // reset during D=A
    vecs[19] = mk(0, 16'hE308, 16'h0000, 4'b1111, 16'd0,    1'b1, 15'd0,     15'd0);   // M=D, D cleared
    vecs[20] = mk(0, 16'hEEA0, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'd0,     15'd1);   // A=-1
    vecs[21] = mk(0, 16'hEA87, 16'h0000, 4'b1111, 16'd0,    1'b0, 15'd32767, 15'd2);   // 0;JMP truncated
    vecs[22] = mk(0, 16'h0000, 16'h0000, 4'b0011, 16'h0000, 1'b0, 15'd32767, 15'd32767); // @0

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].ins, vecs[i].inm);
      if (vecs[i].mask[3]) check($sformatf("v%0d outM", i), outM, vecs[i].out);
      if (vecs[i].mask[2]) check($sformatf("v%0d writeM", i), {15'd0, writeM}, {15'd0, vecs[i].wr});
      if (vecs[i].mask[1]) check($sformatf("v%0d addressM", i), {1'b0, addressM}, {1'b0, vecs[i].addr});
      if (vecs[i].mask[0]) check($sformatf("v%0d pc", i), {1'b0, pc}, {1'b0, vecs[i].pcv});
    end

    // Mid-run reset on a write-everything C-instruction, after D was loaded
    drive(0, 16'h0005, 16'h0000);                         // @5, pc wrapped to 0
    check("seq pc_wrap", {1'b0, pc}, 16'd0);
    drive(0, 16'hEC10, 16'h0000);                         // D=A
    check("seq outM_DA", outM, 16'd5);
    drive(1, 16'hFFFF, 16'h0000);
    check("seq writeM_in_reset", {15'd0, writeM}, 16'd0);
    drive(0, 16'hE308, 16'h0000);                         // M=D after reset
    check("seq pc_after_reset", {1'b0, pc}, 16'd0);
    check("seq addressM_after_reset", {1'b0, addressM}, 16'd0);
    check("seq D_cleared", outM, 16'd0);
    check("seq writeM", {15'd0, writeM}, 16'd1);
    drive(0, 16'h0000, 16'h0000);
    check("seq pc_increment", {1'b0, pc}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
